serial_add_ctrl: RTL and testbench

Bit-serial adder/subtractor controller for the ALU arithmetic path. Accepts two WIDTH-bit operands on a start handshake and sequences a single one-bit full-adder cell over WIDTH cycles, LSB first, with the carry held in a register between bits. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It trades latency for area in the CPU's serial arithmetic option.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_full_adder.sv | 24 ++
 rtl/serial_add_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
//
// Contents:
//   state_e  - controller state encoding (IDLE=0, RUN=1, DONE=2; 3 is illegal
//              and is steered back to IDLE by the controller)
//   full_add - reference one-bit full-adder equation, returned as {carry, sum}
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit combinational full adder cell used by the serial controller.
//
// Ports:
//   a, b   - operand bits
//   c      - carry in
//   sum    - a ^ b ^ c
//   carry  - majority(a, b, c)
module serial_full_adder
  import serial_add_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic [1:0] res;

  assign res   = full_add(a, b, c);
  assign sum   = res[0];
  assign carry = res[1];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller. Accepts two WIDTH-bit operands on a
// start request and feeds them LSB first through a single full-adder cell,
// one bit per cycle, holding the carry in a register between bits.
//
// Ports:
//   i_clk       - clock, rising edge
//   i_reset     - asynchronous active-high reset
//   i_start     - operation request, honoured only in IDLE or DONE
//   i_sub       - 0: A + B + i_cin, 1: A - B (i_cin ignored)
//   i_cin       - carry in for add
//   i_a, i_b    - operands, captured with an accepted start
//   o_busy      - high while bits are being processed
//   o_done      - one-cycle pulse, results valid
//   o_sum       - result, held until the next accepted start
//   o_cout      - carry out of the MSB (for subtract: 1 = no borrow)
//   o_overflow  - signed overflow (carry into MSB xor carry out of MSB)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic fa_sum;
  logic fa_carry;
  logic accept;
  logic last_bit;
  logic msb_cin;

  // Start is only looked at when no operation is in flight.
  assign accept   = i_start && ((state_q == StIdle) || (state_q == StDone));
  assign last_bit = (state_q == StRun) && (cnt_q == CntLast);
  // On the last bit the carry register holds the carry into the MSB.
  assign msb_cin  = carry_q;

  serial_full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = i_start ? StRun : StIdle;
      StRun:   state_d = last_bit ? StDone : StRun;
      StDone:  state_d = i_start ? StRun : StIdle;
      // Illegal encoding recovers to IDLE.
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state_q)
      StRun:   o_busy = 1'b1;
      StDone:  o_done = 1'b1;
      default: begin
        o_busy = 1'b0;
        o_done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry, bit counter and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= i_a;
      // Subtract as A + ~B + 1.
      b_sh_q   <= i_sub ? ~i_b : i_b;
      carry_q  <= i_sub ? 1'b1 : i_cin;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == StRun) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
      carry_q  <= fa_carry;
      if (last_bit) begin
        sum_q  <= {fa_sum, sum_sh_q[WIDTH-1:1]};
        cout_q <= fa_carry;
        ovf_q  <= msb_cin ^ fa_carry;
      end else begin
        // Held on the last bit so the counter never wraps.
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign o_sum      = sum_q;
  assign o_cout     = cout_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 8): directed scenarios with
// literal expectations plus randomized traffic against a cycle-level model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic       cin;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_sub      (sub),
    .i_cin      (cin),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_overflow (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: returns {overflow, cout, sum}.
  function automatic logic [9:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rsub, input logic rcin);
    logic [7:0] bb;
    logic [8:0] full;
    logic       v;
    bb   = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {8'd0, (rsub ? 1'b1 : rcin)};
    v    = (ra[7] == bb[7]) && (full[7] != ra[7]);
    return {v, full[8], full[7:0]};
  endfunction

  // Cycle-level model: an operation occupies W cycles of RUN, then one DONE.
  int         m_left;
  logic       m_done;
  logic [7:0] m_sum;
  logic       m_cout;
  logic       m_ovf;
  logic [9:0] pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = 8'h00;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        {m_ovf, m_cout, m_sum} = pend;
      end
    end else if (start) begin
      m_left = W;
      m_done = 1'b0;
      m_sum  = 8'h00;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
      pend   = ref_op(a, b, sub, cin);
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_busy", busy, m_left > 0);
      check("cmp_done", done, m_done);
      check("cmp_sum", sum, m_sum);
      check("cmp_cout", cout, m_cout);
      check("cmp_ovf", ovf, m_ovf);
    end
  end

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, lat, 8);
  endtask

  task automatic do_op(input string name, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tsub, input logic tcin, input logic [7:0] esum,
                       input logic ecout, input logic eovf);
    int lat;
    @(posedge clk);
    #1;
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    wait_done(name, lat);
    check({name, "_sum"}, sum, esum);
    check({name, "_cout"}, cout, ecout);
    check({name, "_ovf"}, ovf, eovf);
    @(posedge clk);
    #1;
    check({name, "_done_drop"}, done, 1'b0);
    check({name, "_sum_hold"}, sum, esum);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int done_cnt;
    logic [7:0] seen_sum;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    // Pin the reference arithmetic against hand-computed results.
    check("ref_3c_5a", ref_op(8'h3c, 8'h5a, 1'b0, 1'b0), {1'b1, 1'b0, 8'h96});
    check("ref_80_m1", ref_op(8'h80, 8'h01, 1'b1, 1'b0), {1'b1, 1'b1, 8'h7f});
    check("ref_05_m7", ref_op(8'h05, 8'h07, 1'b1, 1'b1), {1'b0, 1'b0, 8'hfe});

    do_op("add_3c5a", 8'h3c, 8'h5a, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op("add_ff01", 8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_cin", 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    do_op("sub_0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hfe, 1'b0, 1'b0);
    do_op("sub_8001", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7f, 1'b1, 1'b1);

    // Start pulses during RUN are dropped.
    @(posedge clk);
    #1;
    a = 8'h10; b = 8'h20; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = 8'haa; b = 8'haa;
    busy_cnt = 0; done_cnt = 0; seen_sum = 8'h00;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        seen_sum = sum;
      end
      start = (cyc == 3 || cyc == 5);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("ign_busy_cycles", busy_cnt, 8);
    check("ign_done_count", done_cnt, 1);
    check("ign_sum", seen_sum, 8'h30);

    // Reset in the middle of a run aborts it.
    @(posedge clk);
    #1;
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done) done_cnt++;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", done_cnt, 0);
    do_op("after_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // Start held through DONE launches the next operation back to back.
    @(posedge clk);
    #1;
    a = 8'h3c; b = 8'h5a; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_sum", sum, 8'h96);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_done_drop", done, 1'b0);
    check("b2b_sum_cleared", sum, 8'h00);
    check("b2b_busy", busy, 1'b1);
    wait_done("b2b_second", lat);
    check("b2b_second_sum", sum, 8'h33);

    // Randomized traffic: starts at any time, occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 3) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
